// File: rtl/spi_link_pkg.sv
// Shared state encoding and header constants for the SPI link scheduler.
package spi_link_pkg;
  typedef enum logic [2:0] {IDLE, SNAP, NEXT, ISSUE, WAIT_DONE, FIN} state_e;

  localparam logic [15:0] HDR_MAGIC   = 16'hA5A5;
  localparam logic [2:0]  HDR_CHAN    = 3'd7;
  localparam int          DEF_DW      = 32;
  localparam int          DEF_TIMEOUT = 1023;
endpackage

// File: rtl/spi_link_scheduler_if.sv
// Word handshake between the link scheduler (master) and the SPI shifter (slave).
interface spi_link_scheduler_if #(parameter int DW = spi_link_pkg::DEF_DW);
  logic          tx_start;
  logic [DW-1:0] tx_word;
  logic [2:0]    tx_chan;
  logic          tx_busy;
  logic          tx_done;

  modport master (output tx_start, tx_word, tx_chan, input tx_busy, tx_done);
  modport slave  (input tx_start, tx_word, tx_chan, output tx_busy, tx_done);
endinterface

// File: rtl/tick_edge_sync.sv
// Two-flop synchroniser plus registered rising-edge pulse; pulse lands 3 clk after the input rises.
module tick_edge_sync (
  input  logic clk,
  input  logic reset,
  input  logic async_in,
  output logic pulse
);
  logic [2:0] sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr    <= '0;
      pulse <= 1'b0;
    end else begin
      sr    <= {sr[1:0], async_in};
      pulse <= sr[1] & ~sr[2];
    end
  end
endmodule

// File: rtl/spi_link_scheduler.sv
// Per-tick frame scheduler feeding channel words to the SPI shifter.
// Optional header word per frame when SPI_LINK_HEADER_EN is defined.
module spi_link_scheduler
  import spi_link_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int DW      = DEF_DW,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                sim_tick,
  input  logic [NCH*DW-1:0]   ch_data,
  input  logic [NCH-1:0]      ch_en,
  spi_link_scheduler_if.master tx,
  output logic                frame_done,
  output logic                overrun,
  output logic                timeout_err,
  output logic [15:0]         frame_cnt
);
`ifdef SPI_LINK_HEADER_EN
  localparam int NDATA = (NCH > 7) ? 7 : NCH;
`else
  localparam int NDATA = NCH;
`endif
  localparam logic [7:0] USE_MASK = 8'((9'd1 << NDATA) - 9'd1);
  localparam int         TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);

  state_e              state;
  logic                tick_p;
  logic [7:0][DW-1:0]  snap;
  logic [7:0]          pend_mask;
  logic [2:0]          idx;
  logic [TW-1:0]       to_cnt;
  logic [7:0]          cand;
  logic                found;
  logic [2:0]          nxt;
`ifdef SPI_LINK_HEADER_EN
  logic                hdr_pend;
  logic [31:0]         hdr_word;
  assign hdr_word = {HDR_MAGIC, frame_cnt[7:0], pend_mask};
`endif

  tick_edge_sync u_tick (.clk(clk), .reset(reset), .async_in(sim_tick), .pulse(tick_p));

  // Lowest pending channel at or above idx.
  always_comb begin
    cand  = pend_mask & (8'hFF << idx);
    found = |cand;
    nxt   = '0;
    for (int i = 7; i >= 0; i--)
      if (cand[i]) nxt = 3'(i);
  end

  // Start is combinational so it fires in the ISSUE cycle itself, the moment the shifter is free.
  assign tx.tx_start = (state == ISSUE) && !tx.tx_busy && !reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      snap        <= '0;
      pend_mask   <= '0;
      idx         <= '0;
      to_cnt      <= '0;
      tx.tx_word  <= '0;
      tx.tx_chan  <= '0;
      frame_done  <= 1'b0;
      overrun     <= 1'b0;
      timeout_err <= 1'b0;
      frame_cnt   <= '0;
`ifdef SPI_LINK_HEADER_EN
      hdr_pend    <= 1'b0;
`endif
    end else begin
      frame_done <= 1'b0;
      if (tick_p && state != IDLE) overrun <= 1'b1;
      case (state)
        IDLE: if (tick_p) state <= SNAP;
        SNAP: begin
          for (int i = 0; i < NCH; i++) snap[i] <= ch_data[i*DW +: DW];
          pend_mask <= 8'(ch_en) & USE_MASK;
          idx       <= '0;
`ifdef SPI_LINK_HEADER_EN
          hdr_pend  <= 1'b1;
`endif
          state     <= NEXT;
        end
        NEXT: begin
`ifdef SPI_LINK_HEADER_EN
          if (hdr_pend) begin
            tx.tx_word <= DW'(hdr_word);
            tx.tx_chan <= HDR_CHAN;
            state      <= ISSUE;
          end else
`endif
          if (found) begin
            idx        <= nxt;
            tx.tx_word <= snap[nxt];
            tx.tx_chan <= nxt;
            state      <= ISSUE;
          end else begin
            state <= FIN;
          end
        end
        ISSUE: if (!tx.tx_busy) begin
`ifdef SPI_LINK_HEADER_EN
          if (hdr_pend) hdr_pend <= 1'b0;
          else
`endif
          pend_mask[idx] <= 1'b0;
          to_cnt <= '0;
          state  <= WAIT_DONE;
        end
        WAIT_DONE: begin
          if (tx.tx_done) begin
            state <= NEXT;
          end else if (to_cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            state       <= NEXT;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end
        FIN: begin
          frame_done <= 1'b1;
          frame_cnt  <= frame_cnt + 16'd1;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_spi_link_scheduler.sv
// Randomised bench for spi_link_scheduler: frame-level expected word queue plus shifter model.
module tb_spi_link_scheduler;
  localparam int NCH = 4;
  localparam int DW  = 32;
  localparam int TO  = 48;

  logic clk, reset, sim_tick;
  logic [NCH-1:0][DW-1:0] data;
  logic [NCH-1:0] ch_en;
  logic frame_done, overrun, timeout_err;
  logic [15:0] frame_cnt;

  spi_link_scheduler_if #(.DW(DW)) tx_if ();

  spi_link_scheduler #(.NCH(NCH), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .sim_tick(sim_tick), .ch_data(data), .ch_en(ch_en),
    .tx(tx_if), .frame_done(frame_done), .overrun(overrun),
    .timeout_err(timeout_err), .frame_cnt(frame_cnt)
  );

  int n_chk = 0, n_err = 0;
  int cyc = 0, rise_cyc = 0, first_start = 0, last_start = -100, last_done = -100;
  int n_in_frame = 0, frames_seen = 0, lat = 40, busy_hold = 0, rel_cyc = 0, rem = 0;
  bit done_mode = 1, gap_chk = 1, to_mode = 0, sh_busy = 0, frame_open = 0, st;
  logic [15:0] fc_model = '0;
  int exp_chan[$];
  logic [31:0] exp_word[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  initial clk = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Shifter: latches start at the edge, busy until done pulses lat cycles later.
  initial begin
    tx_if.tx_busy = 0;
    tx_if.tx_done = 0;
    forever begin
      @(negedge clk);
      st = tx_if.tx_start && !reset;
      @(posedge clk); #1;
      tx_if.tx_done = 0;
      if (st && done_mode) begin
        sh_busy = 1;
        rem = lat;
      end else if (rem > 0) begin
        rem--;
        if (rem == 0) begin sh_busy = 0; tx_if.tx_done = 1; end
      end
      if (busy_hold > 0) begin
        busy_hold--;
        if (busy_hold == 0) rel_cyc = cyc;
      end
      tx_if.tx_busy = sh_busy || (busy_hold > 0);
    end
  end

  // Monitor: every issued word must match the head of the expected queue.
  always @(negedge clk) begin
    int ec;
    logic [31:0] ew;
    if (!reset) begin
      if (tx_if.tx_done) last_done = cyc;
      if (tx_if.tx_start) begin
        chk("start_while_busy", tx_if.tx_busy, 0);
        chk("start_b2b", (cyc - last_start) == 1, 0);
        chk("words_pending", exp_chan.size() > 0, 1);
        if (exp_chan.size() > 0) begin
          ec = exp_chan.pop_front();
          ew = exp_word.pop_front();
          chk("tx_chan", tx_if.tx_chan, ec);
          chk("tx_word", tx_if.tx_word, ew);
        end
        if (gap_chk && n_in_frame > 0) chk("done_to_start", cyc - last_done, 2);
        if (to_mode && n_in_frame > 0) chk("timeout_gap", cyc - last_start, TO + 2);
        if (n_in_frame == 0) first_start = cyc;
        n_in_frame++;
        last_start = cyc;
      end
      if (frame_done) begin
        chk("frame_expected", frame_open, 1);
        chk("words_left", exp_chan.size(), 0);
        fc_model++;
        chk("frame_cnt", frame_cnt, fc_model);
        frame_open = 0;
        n_in_frame = 0;
        frames_seen++;
      end
    end
  end

  task automatic start_frame(input logic [3:0] en, input bit scramble);
    @(posedge clk); #1;
    ch_en = en;
`ifdef SPI_LINK_HEADER_EN
    exp_chan.push_back(7);
    exp_word.push_back({16'hA5A5, fc_model[7:0], 4'b0, en});
`endif
    for (int i = 0; i < NCH; i++)
      if (en[i]) begin exp_chan.push_back(i); exp_word.push_back(data[i]); end
    frame_open = 1;
    rise_cyc = cyc;
    sim_tick = 1;
    repeat (4) begin @(posedge clk); #1; end
    sim_tick = 0;
    if (scramble) begin
      @(posedge clk); #1;
      for (int i = 0; i < NCH; i++) data[i] = $urandom;
    end
  endtask

  task automatic wait_frame(input int budget);
    int f0 = frames_seen;
    int n = 0;
    while (frames_seen == f0 && n < budget) begin @(posedge clk); n++; end
    chk("frame_wait", frames_seen != f0, 1);
    @(posedge clk); #1;
  endtask

  task automatic wait_starts(input int k, input int budget);
    int n = 0;
    while (n_in_frame < k && n < budget) begin @(posedge clk); n++; end
    chk("start_wait", n_in_frame >= k, 1);
  endtask

  task automatic chk_zero();
    chk("rst_tx_start", tx_if.tx_start, 0);
    chk("rst_tx_word", tx_if.tx_word, 0);
    chk("rst_tx_chan", tx_if.tx_chan, 0);
    chk("rst_frame_done", frame_done, 0);
    chk("rst_overrun", overrun, 0);
    chk("rst_timeout_err", timeout_err, 0);
    chk("rst_frame_cnt", frame_cnt, 0);
  endtask

  initial begin
    reset = 1; sim_tick = 0; ch_en = '0; data = '0;
    repeat (3) @(posedge clk);
    #1 reset = 0;
    chk_zero();

    // Full mask, known words, shifter done after 40 cycles.
    data[0] = 32'h11111111; data[1] = 32'h22222222;
    data[2] = 32'h33333333; data[3] = 32'h44444444;
    start_frame(4'b1111, 0);
    wait_frame(1000);
`ifdef SPI_LINK_HEADER_EN
    chk("first_start_lat", first_start - rise_cyc, 6);
`else
    chk("first_start_lat", first_start - rise_cyc, 6);
`endif
    chk("no_timeout", timeout_err, 0);

    // Sparse mask; inputs change right after the snapshot.
    start_frame(4'b1010, 1);
    wait_frame(1000);

    // Empty mask still completes a frame.
    start_frame(4'b0000, 0);
    wait_frame(200);
    chk("no_overrun", overrun, 0);

    // Second tick while word 2 is in flight is dropped.
    start_frame(4'b1111, 0);
    wait_starts(2, 500);
    sim_tick = 1;
    repeat (4) begin @(posedge clk); #1; end
    sim_tick = 0;
    wait_frame(1000);
    chk("overrun_set", overrun, 1);
    repeat (150) @(posedge clk);
    chk("no_extra_frame", frame_open, 0);

    // Shifter busy for 50 cycles from the snapshot onward.
    start_frame(4'b0110, 0);
    @(negedge clk);
    busy_hold = 50;
    gap_chk = 0;
    wait_frame(1000);
    chk("busy_release_start", first_start, rel_cyc);
    gap_chk = 1;

    // Random frames.
    for (int k = 0; k < 12; k++) begin
      lat = $urandom_range(1, 30);
      for (int i = 0; i < NCH; i++) data[i] = $urandom;
      start_frame(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
      wait_frame(2000);
      repeat ($urandom_range(2, 6)) @(posedge clk);
    end
    chk("no_timeout_rand", timeout_err, 0);

    // Shifter never answers: every word abandoned after TO cycles.
    done_mode = 0; gap_chk = 0; to_mode = 1;
    for (int i = 0; i < NCH; i++) data[i] = $urandom;
    start_frame(4'b1111, 0);
    wait_frame(2000);
    chk("timeout_err_set", timeout_err, 1);
    done_mode = 1; to_mode = 0;

    // Reset while a word is in WAIT_DONE, then a clean frame.
    lat = 40;
    start_frame(4'b0101, 0);
    wait_starts(1, 500);
    repeat (5) @(posedge clk);
    #1 reset = 1;
    @(posedge clk); #1 reset = 0;
    chk_zero();
    exp_chan.delete(); exp_word.delete();
    frame_open = 0; n_in_frame = 0; fc_model = '0;
    repeat (60) @(posedge clk);
    gap_chk = 1;
    data[0] = 32'hCAFE0000; data[3] = 32'hBEEF0003;
    start_frame(4'b1001, 0);
    wait_frame(1000);
    chk("clean_frame_cnt", frame_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL global_timeout got=%0d exp=finish", cyc);
    $fatal(1, "bench timed out");
  end
endmodule
